// File: rtl/ct_piu_ctc_snpq.sv
// PIU-side CTC/DVM request queue: grant from CIU, in-order issue to core, completion, tagged response.
// Optional completion timeout enabled by defining CT_PIU_CTC_SNPQ_TIMEOUT_EN.
module ct_piu_ctc_snpq #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ADDRW   = 40,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             ciu_piu_ctc_vld,
  input  logic [ADDRW-1:0] ciu_piu_ctc_addr,
  input  logic [4:0]       ciu_piu_ctc_rid,
  input  logic [3:0]       ciu_piu_ctc_respq_id,
  output logic             piu_ciu_ctc_grnt,
  output logic             piu_core_ctc_vld,
  output logic [ADDRW-1:0] piu_core_ctc_addr,
  input  logic             core_piu_ctc_rdy,
  input  logic             core_piu_ctc_done,
  output logic             piu_ciu_ctc_resp_vld,
  output logic [3:0]       piu_ciu_ctc_resp_respq_id,
  output logic [4:0]       piu_ciu_ctc_resp_rid,
  output logic             piu_ciu_ctc_resp_err,
  input  logic             ciu_piu_ctc_resp_rdy,
  output logic             piu_ctc_idle
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYC < 2) begin : g_param_check
    $error("ct_piu_ctc_snpq: illegal DEPTH or TMO_CYC");
  end

  typedef enum logic [1:0] {FREE, PEND, ISSUED, DONE} ent_state_t;

  ent_state_t       state    [DEPTH];
  logic [ADDRW-1:0] addr_q   [DEPTH];
  logic [4:0]       rid_q    [DEPTH];
  logic [3:0]       respq_q  [DEPTH];

  logic [AW:0]   wr_ptr, iss_ptr, cmp_ptr, rsp_ptr;
  logic [AW-1:0] wr_idx, iss_idx, cmp_idx, rsp_idx;
  logic          full, issue, cmp_issued, cmp_adv, cmp_err, resp_hs;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign iss_idx = iss_ptr[AW-1:0];
  assign cmp_idx = cmp_ptr[AW-1:0];
  assign rsp_idx = rsp_ptr[AW-1:0];

  // Entries stay occupied until their response handshake, so full compares against rsp_ptr.
  assign full = (wr_ptr[AW] != rsp_ptr[AW]) && (wr_idx == rsp_idx);

  assign piu_ciu_ctc_grnt     = ciu_piu_ctc_vld & ~full;
  assign piu_core_ctc_vld     = (state[iss_idx] == PEND);
  assign piu_core_ctc_addr    = addr_q[iss_idx];
  assign issue                = piu_core_ctc_vld & core_piu_ctc_rdy;
  assign cmp_issued           = (state[cmp_idx] == ISSUED);
  assign piu_ciu_ctc_resp_vld = (state[rsp_idx] == DONE);
  assign resp_hs              = piu_ciu_ctc_resp_vld & ciu_piu_ctc_resp_rdy;

  assign piu_ciu_ctc_resp_rid      = piu_ciu_ctc_resp_vld ? rid_q[rsp_idx]   : '0;
  assign piu_ciu_ctc_resp_respq_id = piu_ciu_ctc_resp_vld ? respq_q[rsp_idx] : '0;

`ifdef CT_PIU_CTC_SNPQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYC) + 1;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          err_q [DEPTH];

  // A done pulse in the expiry cycle takes priority, so expiry is masked by done.
  assign tmo_hit = cmp_issued & ~core_piu_ctc_done & (tmo_cnt == TW'(TMO_CYC - 1));
  assign cmp_adv = cmp_issued & (core_piu_ctc_done | tmo_hit);
  assign cmp_err = tmo_hit;
  assign piu_ciu_ctc_resp_err = piu_ciu_ctc_resp_vld & err_q[rsp_idx];

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      tmo_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) err_q[i] <= 1'b0;
    end else begin
      if (cmp_adv || !cmp_issued) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + 1'b1;
      if (cmp_adv) err_q[cmp_idx] <= cmp_err;
    end
  end
`else
  assign cmp_adv = cmp_issued & core_piu_ctc_done;
  assign cmp_err = 1'b0;
  assign piu_ciu_ctc_resp_err = cmp_err;
`endif

  // The four pointers always address distinct entries when they act in the same cycle.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      for (int unsigned i = 0; i < DEPTH; i++) state[i] <= FREE;
      wr_ptr  <= '0;
      iss_ptr <= '0;
      cmp_ptr <= '0;
      rsp_ptr <= '0;
    end else begin
      if (piu_ciu_ctc_grnt) begin
        state[wr_idx] <= PEND;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (issue) begin
        state[iss_idx] <= ISSUED;
        iss_ptr        <= iss_ptr + 1'b1;
      end
      if (cmp_adv) begin
        state[cmp_idx] <= DONE;
        cmp_ptr        <= cmp_ptr + 1'b1;
      end
      if (resp_hs) begin
        state[rsp_idx] <= FREE;
        rsp_ptr        <= rsp_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (piu_ciu_ctc_grnt) begin
      addr_q[wr_idx]  <= ciu_piu_ctc_addr;
      rid_q[wr_idx]   <= ciu_piu_ctc_rid;
      respq_q[wr_idx] <= ciu_piu_ctc_respq_id;
    end
  end

  always_comb begin
    piu_ctc_idle = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (state[i] != FREE) piu_ctc_idle = 1'b0;
  end

endmodule
